adc_ser_emu: RTL and testbench
==============================

ADC_SER_EMU -- requirements
Module: adc_ser_emu

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 12'd1: ramp increment per frame in mode 01.
REQ-002 SHALL have parameter DESKEW_WORD, default 12'hFC0: constant word sent in mode 11.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the port list follows.
REQ-004 clk  in  1  bit-rate clock; all flops rising-edge.
REQ-005 rstb  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  request to transmit frames.
REQ-007 mode  in  2  word source: 00 data, 01 ramp, 10 checkerboard, 11 deskew.
REQ-008 ch_pol  in  8  per-channel polarity, data mode only; bit i = channel i.
REQ-009 in_data  in  96  {CH0,...,CH7}, 12 bits each; CH0 = [95:84].
REQ-010 in_valid  in  1  in_data valid.
REQ-011 in_ready  out  1  one-entry hold register empty.
REQ-012 DCH  out  8  serial data per channel; DCH[i] = channel i.
REQ-013 FCO  out  1  frame clock.
REQ-014 DCO  out  1  bit clock marker.
REQ-015 running  out  1  state == RUN.
REQ-016 underrun  out  1  sticky data-starvation flag.
REQ-017 clr_underrun  in  1  clears underrun.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and RUN, with a 4-bit bit counter bit_cnt (0..11) that is active in RUN.
REQ-019 Frame boundary SHALL be defined as: (IDLE & enable) or (RUN & bit_cnt==11).
- At a boundary with enable=1: load the 8 shift registers, set bit_cnt to 0, enter or stay in RUN.
- At a boundary with enable=0: enter IDLE.
REQ-020 enable SHALL take effect only at a boundary; a frame, once started, always sends all 12 bits.
REQ-021 SHALL transmit MSB first: the MSB appears on DCH in the cycle after the load, the LSB 11 cycles later, with no gap between back-to-back frames.
REQ-022 In RUN, outputs SHALL be driven directly from flops:
- FCO = 1 for bit_cnt 0..5, 0 for 6..11.
- DCO = 1 on even bit_cnt, 0 on odd bit_cnt.
- In IDLE, DCH, FCO and DCO = 0.
REQ-023 mode SHALL be sampled only at a boundary; a mid-frame change has no effect on the current frame.
REQ-024 Mode 00, hold register full: SHALL load from the hold register, with channel i = 4095 - x if ch_pol[i]==0, else x; the hold register becomes empty.
REQ-025 Mode 00, hold register empty: SHALL resend the last transmitted data-mode word (reset value 0) and set underrun.
REQ-026 Mode 01: SHALL send the ramp value r on all channels, then set r = (r + RAMP_STEP) mod 4096; r changes only on ramp frames.
REQ-027 Mode 10: SHALL alternate 12'hAAA and 12'h555 on all channels; the first mode-10 frame after reset is 12'hAAA, and the alternation toggles only on mode-10 frames.
REQ-028 Mode 11: SHALL send DESKEW_WORD on all channels.
REQ-029 Modes 01, 10 and 11 SHALL NOT apply ch_pol and SHALL NOT touch the hold register or the last-data word.
REQ-030 Hold register handshake:
- in_ready SHALL be a registered copy of !hold_full.
- A word is accepted when in_valid & in_ready; hold_full is set on the next cycle.
- Accept and consume SHALL never coincide, because accept requires empty and consume requires full.
REQ-031 When set and clear of underrun coincide, set SHALL win; clr_underrun alone SHALL clear underrun on the next cycle.

Reset
REQ-032 rstb low SHALL immediately force:
- state IDLE, bit_cnt 0;
- DCH, FCO, DCO, running, underrun = 0; in_ready = 1;
- hold register empty, ramp r = 0, checkerboard phase = AAA, last-data word = 0.
REQ-033 Reset asserted mid-frame SHALL truncate the frame immediately.
REQ-034 The first boundary after reset release SHALL be the first cycle in which enable=1 is sampled.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Mode 11, enable=1 from IDLE -> from the next cycle, DCH=8'hFF for 6 cycles then 8'h00 for 6; FCO=111111000000; DCO=101010101010; running=1; repeats with no gap.
- Mode 00, ch_pol=8'hFF, push CH0=12'h800, others 0 -> DCH[0]=100000000000. Repeat with ch_pol[0]=0 -> 011111111111. in_ready is 0 from accept until the load.
- Mode 00, one word pushed, then no in_valid -> the next frame repeats that word and underrun=1. clr_underrun pulse -> underrun=0. Set and clear in the same cycle -> underrun stays 1.
- Mode 01, RAMP_STEP=12'h800 -> frames 000, 800, 000. Switching to mode 10 and back -> the ramp continues from its held value.
- enable dropped at bit_cnt=5 -> all 12 bits sent, then DCH/FCO/DCO=0 and running=0 from the cycle after bit_cnt=11.
- rstb low at bit_cnt=7 -> same-cycle DCH/FCO/DCO=0, in_ready=1, underrun=0. After release with enable=1, a fresh frame starts with the MSB one cycle after release.

Source files
------------

// File: rtl/adc_ser_emu.sv
// Eight-channel serial ADC emulator: 12-bit frames, MSB first, with frame clock
// and bit clock markers, fed from a one-entry hold register or built-in patterns.
module adc_ser_emu #(
  parameter logic [11:0] RAMP_STEP   = 12'd1,
  parameter logic [11:0] DESKEW_WORD = 12'hFC0
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [7:0]  ch_pol,
  input  logic [95:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  DCH,
  output logic        FCO,
  output logic        DCO,
  output logic        running,
  output logic        underrun,
  input  logic        clr_underrun
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [1:0] MODE_DATA   = 2'b00;
  localparam logic [1:0] MODE_RAMP   = 2'b01;
  localparam logic [1:0] MODE_CHECK  = 2'b10;
  localparam logic [1:0] MODE_DESKEW = 2'b11;

  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [11:0] r_shift [8];
  logic        r_fco;
  logic        r_dco;
  logic        r_running;

  logic [95:0] r_hold;
  logic        r_hold_full;
  logic        r_in_ready;
  logic [95:0] r_last;
  logic [11:0] r_ramp;
  logic        r_cb_phase;
  logic        r_underrun;

  logic        w_boundary;
  logic        w_load;
  logic        w_accept;
  logic        w_consume;
  logic        w_starve;
  logic        w_hold_full_nxt;
  logic [11:0] w_word [8];
  logic [95:0] w_word_flat;

  assign w_boundary = ((r_state == ST_IDLE) && enable) ||
                      ((r_state == ST_RUN) && (r_bit_cnt == 4'd11));
  assign w_load     = w_boundary && enable;
  assign w_accept   = in_valid && r_in_ready;
  assign w_consume  = w_load && (mode == MODE_DATA) && r_hold_full;
  assign w_starve   = w_load && (mode == MODE_DATA) && !r_hold_full;

  // Word each channel would start sending if a frame were loaded this cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_word[i] = 12'h000;
    end
    w_word_flat = '0;
    case (mode)
      MODE_DATA: begin
        for (int i = 0; i < 8; i++) begin
          if (r_hold_full) begin
            w_word[i] = ch_pol[i] ? r_hold[95-12*i -: 12] : ~r_hold[95-12*i -: 12];
          end else begin
            w_word[i] = r_last[95-12*i -: 12];
          end
        end
      end
      MODE_RAMP: begin
        for (int i = 0; i < 8; i++) begin
          w_word[i] = r_ramp;
        end
      end
      MODE_CHECK: begin
        for (int i = 0; i < 8; i++) begin
          w_word[i] = r_cb_phase ? 12'h555 : 12'hAAA;
        end
      end
      MODE_DESKEW: begin
        for (int i = 0; i < 8; i++) begin
          w_word[i] = DESKEW_WORD;
        end
      end
      default: begin
        for (int i = 0; i < 8; i++) begin
          w_word[i] = 12'h000;
        end
      end
    endcase
    for (int i = 0; i < 8; i++) begin
      w_word_flat[95-12*i -: 12] = w_word[i];
    end
  end

  // Frame sequencer; shift registers are zeroed on the way to IDLE so DCH idles low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 4'd0;
      r_fco     <= 1'b0;
      r_dco     <= 1'b0;
      r_running <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_shift[i] <= 12'h000;
      end
    end else if (w_boundary) begin
      r_bit_cnt <= 4'd0;
      if (enable) begin
        r_state   <= ST_RUN;
        r_running <= 1'b1;
        r_fco     <= 1'b1;
        r_dco     <= 1'b1;
        for (int i = 0; i < 8; i++) begin
          r_shift[i] <= w_word[i];
        end
      end else begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_fco     <= 1'b0;
        r_dco     <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          r_shift[i] <= 12'h000;
        end
      end
    end else if (r_state == ST_RUN) begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
      r_fco     <= (r_bit_cnt < 4'd5);
      r_dco     <= ~r_dco;
      for (int i = 0; i < 8; i++) begin
        r_shift[i] <= {r_shift[i][10:0], 1'b0};
      end
    end
  end

  // Hold register; in_ready tracks the next full state so it drops right after an accept.
  assign w_hold_full_nxt = w_accept ? 1'b1 : (w_consume ? 1'b0 : r_hold_full);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_hold <= in_data;
      end
      r_hold_full <= w_hold_full_nxt;
      r_in_ready  <= !w_hold_full_nxt;
    end
  end

  // Pattern state only advances on frames of its own mode.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_last     <= '0;
      r_ramp     <= 12'h000;
      r_cb_phase <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_consume) begin
        r_last <= w_word_flat;
      end
      if (w_load && (mode == MODE_RAMP)) begin
        r_ramp <= r_ramp + RAMP_STEP;
      end
      if (w_load && (mode == MODE_CHECK)) begin
        r_cb_phase <= ~r_cb_phase;
      end
      if (w_starve) begin
        r_underrun <= 1'b1;
      end else if (clr_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      DCH[i] = r_shift[i][11];
    end
  end

  assign FCO      = r_fco;
  assign DCO      = r_dco;
  assign running  = r_running;
  assign underrun = r_underrun;
  assign in_ready = r_in_ready;

endmodule

// File: tb/tb_adc_ser_emu.sv
// Directed bench for adc_ser_emu: frame shape, data/polarity path, underrun,
// pattern modes, early disable and mid-frame reset.
module tb_adc_ser_emu;

  logic        clk;
  logic        rstb;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  ch_pol;
  logic [95:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  DCH;
  logic        FCO;
  logic        DCO;
  logic        running;
  logic        underrun;
  logic        clr_underrun;

  int checkCount = 0;
  int errorCount = 0;

  adc_ser_emu #(
    .RAMP_STEP  (12'h800),
    .DESKEW_WORD(12'hFC0)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .enable      (enable),
    .mode        (mode),
    .ch_pol      (ch_pol),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .DCH         (DCH),
    .FCO         (FCO),
    .DCO         (DCO),
    .running     (running),
    .underrun    (underrun),
    .clr_underrun(clr_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle of a frame; checks all 12 bit times against expWords.
  // Data pushes are single-cycle pulses, so in_valid is released after each step.
  task automatic checkFrame(input string tag, input logic [95:0] expWords, input logic dropAt5);
    logic [7:0] expDch;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 8; i++) begin
        expDch[i] = expWords[95-12*i-k];
      end
      checkOutput(tag, {21'd0, running, FCO, DCO, DCH},
                  {21'd0, 1'b1, (k < 6), (k % 2 == 0), expDch});
      if (dropAt5 && k == 5) enable = 1'b0;
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, {21'd0, running, FCO, DCO, DCH}, 32'd0);
  endtask

  task automatic applyStimulus();
    // Reset state
    rstb = 1'b0; enable = 1'b0; mode = 2'b11; ch_pol = 8'hFF;
    in_data = '0; in_valid = 1'b0; clr_underrun = 1'b0;
    tick(); tick();
    checkIdle("reset_outputs");
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_underrun", {31'd0, underrun}, 32'd0);
    rstb = 1'b1;
    tick();
    checkIdle("idle_no_enable");

    // Deskew frames back to back, then enable dropped at bit 5
    enable = 1'b1;
    tick();
    checkFrame("deskew_f1", {8{12'hFC0}}, 1'b0);
    checkFrame("deskew_f2", {8{12'hFC0}}, 1'b0);
    checkFrame("deskew_drop", {8{12'hFC0}}, 1'b1);
    checkIdle("idle_after_drop");
    tick();
    checkIdle("idle_stays");

    // Data mode with polarity
    mode = 2'b00; ch_pol = 8'hFF;
    in_data = {12'h800, 84'd0}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("ready_after_accept", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("ready_held_low", {31'd0, in_ready}, 32'd0);
    enable = 1'b1;
    tick();
    checkOutput("ready_after_load", {31'd0, in_ready}, 32'd1);
    ch_pol = 8'hFE; in_data = {12'h800, 84'd0}; in_valid = 1'b1;
    checkFrame("data_pol1", {12'h800, 84'd0}, 1'b0);
    checkOutput("no_underrun_yet", {31'd0, underrun}, 32'd0);
    checkFrame("data_pol0", {12'h7FF, 84'd0}, 1'b0);

    // Starvation repeats last word and sets underrun
    checkOutput("underrun_set", {31'd0, underrun}, 32'd1);
    checkFrame("data_repeat", {12'h7FF, 84'd0}, 1'b1);
    checkIdle("idle_after_data");
    checkOutput("underrun_sticky", {31'd0, underrun}, 32'd1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    checkOutput("underrun_cleared", {31'd0, underrun}, 32'd0);
    enable = 1'b1; clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    checkOutput("underrun_set_wins", {31'd0, underrun}, 32'd1);
    checkFrame("data_repeat2", {12'h7FF, 84'd0}, 1'b1);
    checkIdle("idle_after_repeat2");

    // Ramp, checkerboard interleaving and mode sampling at boundaries
    mode = 2'b01; enable = 1'b1;
    tick();
    checkFrame("ramp_000", {8{12'h000}}, 1'b0);
    mode = 2'b10;
    checkFrame("ramp_800", {8{12'h800}}, 1'b0);
    mode = 2'b01;
    checkFrame("check_aaa", {8{12'hAAA}}, 1'b0);
    mode = 2'b10;
    checkFrame("ramp_wrap_000", {8{12'h000}}, 1'b0);
    mode = 2'b11;
    checkFrame("check_555", {8{12'h555}}, 1'b0);
    checkFrame("deskew_end", {8{12'hFC0}}, 1'b1);
    checkIdle("idle_after_patterns");

    // Reset in the middle of a frame
    mode = 2'b00; enable = 1'b1;
    tick();
    in_data = {8{12'h123}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checkOutput("pre_reset_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("pre_reset_underrun", {31'd0, underrun}, 32'd1);
    checkOutput("pre_reset_running", {31'd0, running}, 32'd1);
    rstb = 1'b0;
    #1;
    checkIdle("reset_midframe_outputs");
    checkOutput("reset_midframe_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_midframe_underrun", {31'd0, underrun}, 32'd0);
    tick();
    mode = 2'b11;
    rstb = 1'b1;
    tick();
    checkFrame("post_reset_deskew", {8{12'hFC0}}, 1'b1);
    checkIdle("idle_final");
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
